turn_controller: RTL and testbench

Sequences the two-player match: it decides which player holds the turn and converts keyboard presses into a single-frame fire command. It also enforces the per-turn time limit, waits for the projectile to resolve, and detects the end of the game. It sits between the keyboard decoder and the per-player blocks (movement, weapon mode, aiming), which gate their key handling on `p1_in_turn` / `p2_in_turn`.

---
 rtl/game_pkg.sv | 33 +++
 rtl/turn_timer.sv | 46 ++++
 rtl/turn_controller.sv | 157 +++++++++++++++
 tb/tb_turn_controller.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared match-sequencing types and keyboard constants for the
// turn controller, movement and weapon-mode blocks.
`default_nettype none

package game_pkg;

  typedef enum logic [2:0] {
    READY  = 3'd0,
    AIM    = 3'd1,
    FLIGHT = 3'd2,
    SETTLE = 3'd3,
    OVER   = 3'd4
  } state_t;

  typedef enum logic {
    P1 = 1'b0,
    P2 = 1'b1
  } player_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_t;

  localparam logic [7:0] KEY_ENTER = 8'd40;
  localparam logic [7:0] KEY_SPACE = 8'd44;
  localparam logic [7:0] KEY_C     = 8'd6;

endpackage

`default_nettype wire

// File: rtl/turn_timer.sv
// turn_timer: per-turn frame divider and seconds down-counter; expire flags
// the frame whose closing edge steps turn_sec from 1 to 0.
`default_nettype none

module turn_timer #(
  parameter int FRAMES_PER_SEC = 60,
  parameter int TURN_SECONDS   = 15
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       load,
  input  logic       run,
  output logic [4:0] turn_sec,
  output logic       expire
);

  localparam logic [5:0] FRAME_LAST = 6'(FRAMES_PER_SEC - 1);
  localparam logic [4:0] SEC_INIT   = 5'(TURN_SECONDS);

  logic [5:0] frame_cnt;
  logic       wrap;

  assign wrap   = run && (frame_cnt == FRAME_LAST);
  // Combinational so the controller can leave AIM on the same edge the count hits 0.
  assign expire = wrap && (turn_sec == 5'd1);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      frame_cnt <= 6'd0;
      turn_sec  <= SEC_INIT;
    end else if (load) begin
      frame_cnt <= 6'd0;
      turn_sec  <= SEC_INIT;
    end else if (run) begin
      if (wrap) begin
        frame_cnt <= 6'd0;
        if (turn_sec != 5'd0) turn_sec <= turn_sec - 5'd1;
      end else begin
        frame_cnt <= frame_cnt + 6'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/turn_controller.sv
// turn_controller: two-player match sequencer -- turn ownership, fire pulse,
// turn time limit, projectile wait, settle pause and end-of-game detection.
`default_nettype none

module turn_controller
  import game_pkg::*;
#(
  parameter int FRAMES_PER_SEC = 60,
  parameter int TURN_SECONDS   = 15,
  parameter int SETTLE_FRAMES  = 30,
  parameter int FLIGHT_TIMEOUT = 255
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       proj_done,
  input  logic       p1_dead,
  input  logic       p2_dead,
  output logic       p1_in_turn,
  output logic       p2_in_turn,
  output logic       fire,
  output logic [4:0] turn_sec,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_FRAMES);
  localparam logic [7:0] FLIGHT_LAST = 8'(FLIGHT_TIMEOUT);

  state_t     state;
  player_t    player;
  logic [7:0] prev_key;
  logic [7:0] cnt;

  logic press_enter;
  logic press_space;
  logic settle_done;
  logic any_dead;
  logic flight_done;
  logic timer_load;
  logic timer_run;
  logic timer_expire;

  assign press_enter = (keycode == KEY_ENTER) && (prev_key != KEY_ENTER);
  assign press_space = (keycode == KEY_SPACE) && (prev_key != KEY_SPACE);
  assign settle_done = (state == SETTLE) && (cnt >= SETTLE_LAST);
  assign any_dead    = p1_dead || p2_dead;
  // fire is high only in the first FLIGHT frame, so it masks proj_done there.
  assign flight_done = (!fire && proj_done) || (cnt >= FLIGHT_LAST);

  assign timer_run  = (state == AIM);
  assign timer_load = ((state == READY) && press_enter) ||
                      ((state == OVER) && press_enter)  ||
                      (settle_done && !any_dead);

  turn_timer #(
    .FRAMES_PER_SEC(FRAMES_PER_SEC),
    .TURN_SECONDS  (TURN_SECONDS)
  ) u_turn_timer (
    .frame_clk(frame_clk),
    .Reset    (Reset),
    .load     (timer_load),
    .run      (timer_run),
    .turn_sec (turn_sec),
    .expire   (timer_expire)
  );

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state      <= READY;
      player     <= P1;
      prev_key   <= 8'd0;
      cnt        <= 8'd0;
      fire       <= 1'b0;
      p1_in_turn <= 1'b0;
      p2_in_turn <= 1'b0;
      game_over  <= 1'b0;
      winner     <= WIN_NONE;
    end else begin
      prev_key <= keycode;
      fire     <= 1'b0;
      case (state)
        READY: begin
          if (press_enter) begin
            state      <= AIM;
            player     <= P1;
            p1_in_turn <= 1'b1;
            p2_in_turn <= 1'b0;
          end
        end
        AIM: begin
          // A press in the expiry frame still fires.
          if (press_space) begin
            state      <= FLIGHT;
            fire       <= 1'b1;
            cnt        <= 8'd1;
            p1_in_turn <= 1'b0;
            p2_in_turn <= 1'b0;
          end else if (timer_expire) begin
            state      <= SETTLE;
            cnt        <= 8'd1;
            p1_in_turn <= 1'b0;
            p2_in_turn <= 1'b0;
          end
        end
        FLIGHT: begin
          if (flight_done) begin
            state <= SETTLE;
            cnt   <= 8'd1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        SETTLE: begin
          if (settle_done) begin
            if (p1_dead && p2_dead) begin
              state     <= OVER;
              game_over <= 1'b1;
              winner    <= WIN_DRAW;
            end else if (p2_dead) begin
              state     <= OVER;
              game_over <= 1'b1;
              winner    <= WIN_P1;
            end else if (p1_dead) begin
              state     <= OVER;
              game_over <= 1'b1;
              winner    <= WIN_P2;
            end else begin
              state      <= AIM;
              player     <= (player == P1) ? P2 : P1;
              p1_in_turn <= (player == P2);
              p2_in_turn <= (player == P1);
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        OVER: begin
          if (press_enter) begin
            state     <= READY;
            player    <= P1;
            game_over <= 1'b0;
            winner    <= WIN_NONE;
          end
        end
        default: begin
          state      <= READY;
          p1_in_turn <= 1'b0;
          p2_in_turn <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_turn_controller.sv
// tb_turn_controller: directed plus random stimulus against a frame-level
// reference model of the match rules.
`default_nettype none

module tb_turn_controller;

  localparam int FPS = 4;
  localparam int TS  = 3;
  localparam int SF  = 2;
  localparam int FT  = 10;

  localparam int PH_READY  = 0;
  localparam int PH_AIM    = 1;
  localparam int PH_FLIGHT = 2;
  localparam int PH_SETTLE = 3;
  localparam int PH_OVER   = 4;

  logic       frame_clk = 1'b0;
  logic       Reset     = 1'b1;
  logic [7:0] keycode   = 8'd0;
  logic       proj_done = 1'b0;
  logic       p1_dead   = 1'b0;
  logic       p2_dead   = 1'b0;
  logic       p1_in_turn, p2_in_turn, fire, game_over;
  logic [4:0] turn_sec;
  logic [1:0] winner;

  int n_checks = 0;
  int n_fail   = 0;

  turn_controller #(
    .FRAMES_PER_SEC(FPS),
    .TURN_SECONDS  (TS),
    .SETTLE_FRAMES (SF),
    .FLIGHT_TIMEOUT(FT)
  ) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .proj_done (proj_done),
    .p1_dead   (p1_dead),
    .p2_dead   (p2_dead),
    .p1_in_turn(p1_in_turn),
    .p2_in_turn(p2_in_turn),
    .fire      (fire),
    .turn_sec  (turn_sec),
    .game_over (game_over),
    .winner    (winner)
  );

  always #5 frame_clk = ~frame_clk;

  // Reference model: which phase of the match we are in and how many frames
  // have elapsed in it; outputs are derived from those counts.
  int         m_phase, m_player, m_aim_done, m_fl, m_st, m_win;
  logic [7:0] m_prev;
  bit         m_sec_known;

  task automatic model_reset();
    m_phase = PH_READY; m_player = 0; m_aim_done = 0;
    m_fl = 0; m_st = 0; m_win = 0; m_prev = 8'd0; m_sec_known = 1'b1;
  endtask

  task automatic model_edge(input logic [7:0] k, input logic pd, input logic d1, input logic d2);
    bit pe, ps;
    pe = (k == 8'd40) && (m_prev != 8'd40);
    ps = (k == 8'd44) && (m_prev != 8'd44);
    case (m_phase)
      PH_READY: if (pe) begin
        m_phase = PH_AIM; m_player = 0; m_aim_done = 0; m_sec_known = 1'b1;
      end
      PH_AIM: begin
        m_aim_done++;
        if (ps) begin
          m_phase = PH_FLIGHT; m_fl = 1;
        end else if (m_aim_done == TS * FPS) begin
          m_phase = PH_SETTLE; m_st = 1;
        end
      end
      PH_FLIGHT: begin
        if ((m_fl > 1 && pd) || m_fl == FT) begin
          m_phase = PH_SETTLE; m_st = 1;
        end else m_fl++;
      end
      PH_SETTLE: begin
        if (m_st == SF) begin
          if (d1 || d2) begin
            m_phase = PH_OVER;
            m_win = (d2 ? 1 : 0) + (d1 ? 2 : 0);
          end else begin
            m_player = 1 - m_player; m_phase = PH_AIM; m_aim_done = 0;
          end
        end else m_st++;
      end
      PH_OVER: if (pe) begin
        m_phase = PH_READY; m_win = 0; m_player = 0; m_sec_known = 1'b0;
      end
      default: m_phase = PH_READY;
    endcase
    m_prev = k;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("fire", {7'd0, fire}, {7'd0, (m_phase == PH_FLIGHT && m_fl == 1)});
    check("p1_in_turn", {7'd0, p1_in_turn}, {7'd0, (m_phase == PH_AIM && m_player == 0)});
    check("p2_in_turn", {7'd0, p2_in_turn}, {7'd0, (m_phase == PH_AIM && m_player == 1)});
    check("game_over", {7'd0, game_over}, {7'd0, (m_phase == PH_OVER)});
    check("winner", {6'd0, winner}, 8'(m_win));
    if (m_sec_known) check("turn_sec", {3'd0, turn_sec}, 8'(TS - m_aim_done / FPS));
  endtask

  task automatic step(input logic [7:0] k, input logic pd = 1'b0,
                      input logic d1 = 1'b0, input logic d2 = 1'b0);
    keycode = k; proj_done = pd; p1_dead = d1; p2_dead = d2;
    @(posedge frame_clk);
    model_edge(k, pd, d1, d2);
    #1;
    check_all();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         fires;
    logic [7:0] rk;
    model_reset();
    repeat (2) @(posedge frame_clk);
    #1;
    check_all();
    check("reset_turn_sec", {3'd0, turn_sec}, 8'd3);
    Reset = 1'b0;

    // Start and fire
    step(8'd40);
    check("start_p1", {7'd0, p1_in_turn}, 8'd1);
    repeat (5) step(8'd0);
    step(8'd44);
    check("fire_pulse", {7'd0, fire}, 8'd1);
    check("fire_p1_low", {7'd0, p1_in_turn}, 8'd0);
    step(8'd0);
    check("fire_one_frame", {7'd0, fire}, 8'd0);
    step(8'd0);
    step(8'd0, 1'b1);
    step(8'd0);
    step(8'd0);
    check("handover_p2", {7'd0, p2_in_turn}, 8'd1);
    check("handover_sec", {3'd0, turn_sec}, 8'd3);

    // Held SPACE through the handover back to P1
    fires = 0;
    repeat (20) begin
      step(8'd44);
      fires += int'(fire);
    end
    check("held_one_fire", 8'(fires), 8'd1);
    check("held_p1_turn", {7'd0, p1_in_turn}, 8'd1);
    step(8'd0);
    step(8'd44);
    check("repress_fire", {7'd0, fire}, 8'd1);

    // Flight timeout: proj_done never arrives
    repeat (11) step(8'd0);
    check("flight_to_settle", {7'd0, p2_in_turn}, 8'd0);
    step(8'd0);
    check("flight_timeout_handover", {7'd0, p2_in_turn}, 8'd1);

    // Turn timeout for P2
    fires = 0;
    for (int i = 0; i < TS * FPS; i++) begin
      check("timeout_sec", {3'd0, turn_sec}, 8'(TS - i / FPS));
      step(8'd0);
      fires += int'(fire);
    end
    check("timeout_sec_zero", {3'd0, turn_sec}, 8'd0);
    check("timeout_no_fire", 8'(fires), 8'd0);
    step(8'd0);
    step(8'd0);
    check("timeout_handover", {7'd0, p1_in_turn}, 8'd1);

    // Game end: P2 dies; proj_done in the fire frame is ignored
    step(8'd44);
    step(8'd0, 1'b1);
    step(8'd0, 1'b1);
    step(8'd0, 1'b0, 1'b0, 1'b1);
    step(8'd0, 1'b0, 1'b0, 1'b1);
    check("p1_wins", {6'd0, winner}, 8'd1);
    check("over_flag", {7'd0, game_over}, 8'd1);
    check("over_no_turn", {6'd0, p1_in_turn, p2_in_turn}, 8'd0);
    step(8'd0);
    step(8'd40);
    check("over_to_ready", {6'd0, winner}, 8'd0);
    step(8'd0);
    step(8'd40);
    step(8'd44);
    step(8'd0, 1'b1);
    step(8'd0, 1'b1);
    step(8'd0, 1'b0, 1'b1, 1'b1);
    step(8'd0, 1'b0, 1'b1, 1'b1);
    check("draw", {6'd0, winner}, 8'd3);
    step(8'd0);
    step(8'd40);

    // Random play
    rk = 8'd0;
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 9) < 4) begin
        case ($urandom_range(0, 7))
          0, 1, 2: rk = 8'd0;
          3:       rk = 8'd40;
          4, 5:    rk = 8'd44;
          6:       rk = 8'd6;
          default: rk = 8'($urandom_range(1, 255));
        endcase
      end
      step(rk, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0);
    end

    // Reset in the fire frame
    Reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge frame_clk);
    #1;
    Reset = 1'b0;
    step(8'd0);
    step(8'd40);
    step(8'd44);
    check("pre_reset_fire", {7'd0, fire}, 8'd1);
    #2;
    Reset = 1'b1;
    #1;
    model_reset();
    check("async_fire_drop", {7'd0, fire}, 8'd0);
    check("async_sec", {3'd0, turn_sec}, 8'd3);
    check_all();
    @(posedge frame_clk);
    #1;
    Reset = 1'b0;
    step(8'd0);
    step(8'd40);
    check("restart_p1", {7'd0, p1_in_turn}, 8'd1);
    step(8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
